// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register slave: ID, SCRATCH, CTRL, STATUS and a free-running CYCLES counter
// in a 16-word window. One outstanding write and one outstanding read at a time.
module axi4l_reg_slave #(
  parameter logic [31:0] ID_VALUE   = 32'h5A7A_0001,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           ctrl_o,
  input  logic [31:0]           status_i
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_CYCLES  = IDX_W'(4);

  logic              aw_held, w_held;
  logic              aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [IDX_W-1:0]  aw_idx;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic [DATA_W-1:0] scratch, cycles, status_q;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp, wr_resp;
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, do_write;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid  & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;
  assign b_hs     = s_axi_bvalid  & s_axi_bready;
  assign r_hs     = s_axi_rvalid  & s_axi_rready;
  assign do_write = aw_held & w_held;
  assign ar_idx   = s_axi_araddr[ADDR_WIDTH-1:2];
  assign wr_resp  = (aw_idx <= IDX_CYCLES) ? RESP_OKAY : RESP_SLVERR;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Channel next-state: capture AW/W independently, commit once both are held.
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = s_axi_bvalid;
    rvalid_n  = s_axi_rvalid;
    if (aw_hs) aw_held_n = 1'b1;
    if (w_hs)  w_held_n  = 1'b1;
    if (do_write) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b1;
    end else if (b_hs) begin
      bvalid_n = 1'b0;
    end
    if (ar_hs)     rvalid_n = 1'b1;
    else if (r_hs) rvalid_n = 1'b0;
  end

  // Read mux sees current register values, so a coincident write returns the old value.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      IDX_ID:      rd_data = ID_VALUE;
      IDX_SCRATCH: rd_data = scratch;
      IDX_CTRL:    rd_data = ctrl_o;
      IDX_STATUS:  rd_data = status_q;
      IDX_CYCLES:  rd_data = cycles;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // Channel state and registered handshake outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      s_axi_awready <= ~aw_held_n & ~bvalid_n;
      s_axi_wready  <= ~w_held_n & ~bvalid_n;
      s_axi_arready <= ~rvalid_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_rvalid  <= rvalid_n;
      if (aw_hs) aw_idx <= s_axi_awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (do_write) s_axi_bresp <= wr_resp;
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_resp;
      end
    end
  end

  // Register file; a CYCLES write wins over the increment.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scratch  <= '0;
      ctrl_o   <= '0;
      cycles   <= '0;
      status_q <= '0;
    end else begin
      status_q <= status_i;
      cycles   <= (do_write && aw_idx == IDX_CYCLES) ? '0 : cycles + DATA_W'(1);
      if (do_write) begin
        case (aw_idx)
          IDX_SCRATCH: scratch <= merge_bytes(scratch, w_data, w_strb);
          IDX_CTRL:    ctrl_o  <= merge_bytes(ctrl_o, w_data, w_strb);
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: doc/axi4l_reg_slave.md
AXI4L_REG_SLAVE -- requirements
Module: axi4l_reg_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5A7A_0001, constant returned by the ID register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, byte-address width of the register window (16 words).
REQ-003 SHALL use one clock and an asynchronous active-low reset: aclk input 1, rising-edge clock for all logic; aresetn input 1, asynchronous active-low reset.
REQ-004 SHALL have the write-address ports: s_axi_awaddr input ADDR_WIDTH; s_axi_awvalid input 1; s_axi_awready output 1.
REQ-005 SHALL have the write-data ports: s_axi_wdata input 32; s_axi_wstrb input 4; s_axi_wvalid input 1; s_axi_wready output 1.
REQ-006 SHALL have the write-response ports: s_axi_bresp output 2; s_axi_bvalid output 1; s_axi_bready input 1.
REQ-007 SHALL have the read-address ports: s_axi_araddr input ADDR_WIDTH; s_axi_arvalid input 1; s_axi_arready output 1.
REQ-008 SHALL have the read-data ports: s_axi_rdata output 32; s_axi_rresp output 2; s_axi_rvalid output 1; s_axi_rready input 1.
REQ-009 SHALL have the user ports: ctrl_o output 32, CTRL register contents; status_i input 32, sampled status.

Function
REQ-010 SHALL decode the word address as addr[ADDR_WIDTH-1:2] and ignore addr[1:0].
- 0x00 ID: read-only, returns ID_VALUE.
- 0x04 SCRATCH: read/write.
- 0x08 CTRL: read/write, drives ctrl_o.
- 0x0C STATUS: read-only, returns status_i registered once.
- 0x10 CYCLES: read-only, 32-bit free-running counter that wraps 0xFFFFFFFF -> 0; any write clears it to 0.
REQ-011 SHALL treat all other addresses as unmapped: writes are ignored with OKAY resp replaced by SLVERR (2'b10); reads return rdata 0 with SLVERR.
REQ-012 SHALL return OKAY (2'b00) on every mapped access, including writes to ID and STATUS, which have no effect.
REQ-013 SHALL capture AW and W independently.
- awready=1 while no address is held and bvalid=0; wready=1 while no data is held and bvalid=0.
- Each channel's ready drops the cycle after its own handshake.
REQ-014 SHALL perform the register write in the cycle after both address and data are held, and assert bvalid in that same cycle.
REQ-015 SHALL hold bvalid and bresp stable until bready; bvalid clears on the handshake cycle.
REQ-016 SHALL accept no new AW or W while bvalid=1 (one outstanding write).
REQ-017 SHALL apply byte strobes to SCRATCH and CTRL: wstrb[n] updates bits [8n+7:8n], and wstrb=0 leaves the register unchanged with OKAY.
REQ-018 SHALL handle reads as follows.
- arready=1 when rvalid=0.
- On the AR handshake, rdata/rresp are registered and rvalid=1 the next cycle (latency 1).
- rdata, rresp and rvalid stay stable until rready; arready=0 while rvalid=1.
REQ-019 SHALL return the pre-write value when a read handshake and a register write land in the same cycle on the same register.
REQ-020 SHALL give CYCLES clear priority over increment when the clear and the increment coincide; the counter reads 0 on the following cycle.
REQ-021 SHALL operate the read and write channels concurrently with no mutual stalling.

Reset
REQ-022 SHALL, while aresetn=0, force asynchronously:
- awready=0, wready=0, arready=0, bvalid=0, rvalid=0;
- bresp=0, rresp=0, rdata=0;
- SCRATCH=0, CTRL=0, ctrl_o=0, CYCLES=0;
- held address/data flags cleared.
REQ-023 SHALL deassert reset synchronously to aclk, with the ready signals rising no earlier than the first aclk edge after aresetn goes high.
REQ-024 SHALL discard any transaction in flight when reset asserts mid-transfer; no response is issued afterwards.

Verification
REQ-025 SHALL pass: read 0x00 -> rvalid one cycle after AR, rdata=32'h5A7A0001, rresp=00.
REQ-026 SHALL pass: W presented 3 cycles before AW to 0x08 data 0xDEADBEEF, wstrb=4'b0101 -> ctrl_o=0x00AD00EF, single bvalid, bresp=00.
REQ-027 SHALL pass: write 0x3C, then read 0x3C -> bresp=10; rdata=0, rresp=10; SCRATCH/CTRL unchanged.
REQ-028 SHALL pass: bready held low 5 cycles after write -> bvalid/bresp stable; awready=wready=0 throughout; second write accepted after handshake.
REQ-029 SHALL pass: write any value to 0x10, then read 0x10 N cycles later -> rdata equals the cycle count since the clear (within ±1 per REQ-020 timing); the counter, forced to 0xFFFFFFFF, wraps to 0.
REQ-030 SHALL pass: aresetn pulsed low while rvalid=1 and rready=0 -> rvalid drops immediately, ctrl_o=0, and no stale response is issued after reset.
